horiz_servo_pwm: RTL

Horizontal-axis servo driver for the solar tracker. Holds the servo angle in degrees, steps it left or right on request from the horizontal sweep logic, generates the 50 Hz servo PWM pulse, and raises `PWM_limit` when the angle reaches its upper bound (180°). It sits between the horizontal sweep/max state machine and the servo pin; `PWM_limit` feeds the horizontal sweep counter.

---
 rtl/servo_pkg.sv | 41 ++++
 rtl/servo_frame_timer.sv | 68 ++++++
 rtl/horiz_servo_pwm.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared servo definitions for the solar tracker axes.
//
// Holds the default frame/pulse timing for a 100 MHz clock, the angle
// width used on the POS outputs, and the step-direction decision that
// both the horizontal and vertical drivers use at a step boundary.
package servo_pkg;

  // Angle in whole degrees, 0..MAX_DEG.
  localparam int ANGLE_W = 8;

  // Default timing at 100 MHz.
  localparam int DEF_PERIOD_CYC    = 2_000_000;  // 20 ms frame
  localparam int DEF_MIN_PULSE_CYC = 50_000;     // 0.5 ms at 0 degrees
  localparam int DEF_DEG_CYC       = 1_111;      // pulse growth per degree
  localparam int DEF_MAX_DEG       = 180;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_dir_e;

  // Decide what one step boundary does to the angle. Conflicting
  // requests, no request, or a request into a bound all hold, so the
  // angle saturates instead of wrapping.
  function automatic step_dir_e step_decide(
    input logic               en,
    input logic               move_r,
    input logic               move_l,
    input logic [ANGLE_W-1:0] angle,
    input logic [ANGLE_W-1:0] max_angle
  );
    step_decide = STEP_HOLD;
    if (en && move_r && !move_l && (angle < max_angle)) begin
      step_decide = STEP_INC;
    end else if (en && move_l && !move_r && (angle != '0)) begin
      step_decide = STEP_DEC;
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame and step timing for a servo driver.
//
// The frame counter runs 0..PERIOD_CYC-1 continuously. The step counter
// advances once per frame and marks every STEP_FRAMES-th frame end as a
// step boundary, which is the only cycle the angle may change in.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   frame_cnt   - current position inside the frame
//   step_bound  - high in the last cycle of a frame that ends a step period
//   frame       - one-cycle strobe, high the cycle after the counter has
//                 wrapped to 0 (lines up with the first high PWM cycle)
module servo_frame_timer #(
  parameter int PERIOD_CYC  = 2_000_000,
  parameter int STEP_FRAMES = 1,
  parameter int CNT_W       = $clog2(PERIOD_CYC)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             step_bound,
  output logic             frame
);

  // Wide enough to hold STEP_FRAMES-1 and never zero width.
  localparam int STEP_W = $clog2(STEP_FRAMES + 1);

  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              wrap_d1_q, wrap_d1_d;
  logic              frame_q, frame_d;
  logic              wrap;
  logic              step_last;

  always_comb begin
    wrap        = (frame_cnt_q == CNT_W'(PERIOD_CYC - 1));
    step_last   = (step_cnt_q == STEP_W'(STEP_FRAMES - 1));
    frame_cnt_d = wrap ? '0 : frame_cnt_q + CNT_W'(1);
    step_cnt_d  = step_cnt_q;
    if (wrap) begin
      step_cnt_d = step_last ? '0 : step_cnt_q + STEP_W'(1);
    end
    // Two stages: the counter sits at 0 one cycle after wrap, and FRAME
    // is due the cycle after that, together with the registered PWM rise.
    // The frame that starts out of reset has no wrap, so no FRAME.
    wrap_d1_d = wrap;
    frame_d   = wrap_d1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      step_cnt_q  <= '0;
      wrap_d1_q   <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      step_cnt_q  <= step_cnt_d;
      wrap_d1_q   <= wrap_d1_d;
      frame_q     <= frame_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign step_bound = wrap & step_last;
  assign frame      = frame_q;

endmodule

// File: rtl/horiz_servo_pwm.sv
// Horizontal-axis servo driver for the solar tracker.
//
// Holds the servo angle, steps it by one degree at step boundaries on
// request from the sweep logic, and produces the 50 Hz servo pulse whose
// width is kept incrementally in a pulse register (no multiplier).
//
// Ports:
//   CLK, RST   - clock, asynchronous active-high reset
//   EN         - servo enable; stepping only happens while high
//   MOVE_R     - level request for +1 degree at the next step boundary
//   MOVE_L     - level request for -1 degree at the next step boundary
//   PWM        - registered servo pulse, pulse-register cycles wide
//   PWM_limit  - high while the angle is MAX_DEG
//   PWM_zero   - high while the angle is 0
//   POS        - current angle in degrees
//   FRAME      - one-cycle strobe aligned with the first PWM cycle of a frame
//
// Build option: define SERVO_IDLE_EN to unpower the servo (PWM held low)
// while EN is low; output resumes at the first full frame after EN rises.
// Without it the pulse continues at the held angle for holding torque.
module horiz_servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter int DEG_CYC       = DEF_DEG_CYC,
  parameter int MAX_DEG       = DEF_MAX_DEG,
  parameter int RESET_DEG     = 90,
  parameter int STEP_FRAMES   = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               MOVE_R,
  input  logic               MOVE_L,
  output logic               PWM,
  output logic               PWM_limit,
  output logic               PWM_zero,
  output logic [ANGLE_W-1:0] POS,
  output logic               FRAME
);

  localparam int CNT_W   = $clog2(PERIOD_CYC);
  localparam int PULSE_W = $clog2(MIN_PULSE_CYC + MAX_DEG * DEG_CYC + 1);
  localparam int CMP_W   = (CNT_W > PULSE_W) ? CNT_W : PULSE_W;

  logic [CNT_W-1:0]   frame_cnt;
  logic               step_bound;
  logic               frame;

  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic               limit_q, limit_d;
  logic               zero_q, zero_d;
  logic               pwm_q, pwm_d;
  logic               in_pulse;
  step_dir_e          step_dir;

`ifdef SERVO_IDLE_EN
  // Set at a frame start while enabled; gates PWM so a frame entered
  // part-way after EN rises never emits a partial pulse.
  logic               pwm_on_q, pwm_on_d;
  logic               frame_start;
`endif

  servo_frame_timer #(
    .PERIOD_CYC  (PERIOD_CYC),
    .STEP_FRAMES (STEP_FRAMES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .frame_cnt  (frame_cnt),
    .step_bound (step_bound),
    .frame      (frame)
  );

  always_comb begin
    step_dir = step_decide(EN, MOVE_R, MOVE_L, angle_q, ANGLE_W'(MAX_DEG));
    angle_d  = angle_q;
    pulse_d  = pulse_q;
    // The step boundary is the last frame cycle, so a new pulse width is
    // first compared at frame count 0 and no pulse is cut or stretched.
    if (step_bound) begin
      case (step_dir)
        STEP_INC: begin
          angle_d = angle_q + ANGLE_W'(1);
          pulse_d = pulse_q + PULSE_W'(DEG_CYC);
        end
        STEP_DEC: begin
          angle_d = angle_q - ANGLE_W'(1);
          pulse_d = pulse_q - PULSE_W'(DEG_CYC);
        end
        default: begin
          angle_d = angle_q;
          pulse_d = pulse_q;
        end
      endcase
    end
    // Flags compare the next angle so they move on the same edge as POS.
    limit_d  = (angle_d == ANGLE_W'(MAX_DEG));
    zero_d   = (angle_d == '0);
    in_pulse = (CMP_W'(frame_cnt) < CMP_W'(pulse_q));
`ifdef SERVO_IDLE_EN
    frame_start = (frame_cnt == '0);
    pwm_on_d    = pwm_on_q;
    if (!EN) begin
      pwm_on_d = 1'b0;
    end else if (frame_start) begin
      pwm_on_d = 1'b1;
    end
    pwm_d = in_pulse & EN & (pwm_on_q | frame_start);
`else
    pwm_d = in_pulse;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      angle_q <= ANGLE_W'(RESET_DEG);
      pulse_q <= PULSE_W'(MIN_PULSE_CYC + RESET_DEG * DEG_CYC);
      limit_q <= (RESET_DEG == MAX_DEG);
      zero_q  <= (RESET_DEG == 0);
      pwm_q   <= 1'b0;
    end else begin
      angle_q <= angle_d;
      pulse_q <= pulse_d;
      limit_q <= limit_d;
      zero_q  <= zero_d;
      pwm_q   <= pwm_d;
    end
  end

`ifdef SERVO_IDLE_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_on_q <= 1'b0;
    end else begin
      pwm_on_q <= pwm_on_d;
    end
  end
`endif

  assign PWM       = pwm_q;
  assign PWM_limit = limit_q;
  assign PWM_zero  = zero_q;
  assign POS       = angle_q;
  assign FRAME     = frame;

endmodule
